// File: rtl/div_unit.sv
// Multi-cycle restoring integer divide/modulo unit with ready/valid handshake.
// Serves full-width and half-width operands, signed or unsigned per command.
module div_unit #(
  parameter int unsigned WIDTH          = 64,
  parameter int unsigned ITER_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic             in_half,
  input  logic [WIDTH-1:0] in_num,
  input  logic [WIDTH-1:0] in_denom,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_div_zero,
  output logic             out_ovf
);

  localparam int unsigned HALF  = WIDTH / 2;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  // Reject illegal parameter combinations at elaboration
  if ((WIDTH < 8) || ((WIDTH % 2) != 0) ||
      ((ITER_PER_CYCLE != 1) && (ITER_PER_CYCLE != 2)) ||
      ((HALF % ITER_PER_CYCLE) != 0)) begin : g_param_check
    $error("div_unit: illegal WIDTH/ITER_PER_CYCLE combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] d_r;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] num_ext;
  logic [WIDTH-1:0] den_ext;
  logic [WIDTH-1:0] num_mag;
  logic [WIDTH-1:0] den_mag;
  logic [WIDTH-1:0] min_ext;
  logic [WIDTH-1:0] ones_ext;
  logic [WIDTH-1:0] load_q;
  logic [CNT_W-1:0] load_cnt;
  logic             num_neg;
  logic             den_neg;
  logic             den_zero;
  logic             is_ovf;

  // Operand decode: extend the active N bits, detect special cases, take magnitudes
  always_comb begin
    if (in_half) begin
      num_ext  = in_signed ? {{HALF{in_num[HALF-1]}}, in_num[HALF-1:0]}
                           : {{HALF{1'b0}}, in_num[HALF-1:0]};
      den_ext  = in_signed ? {{HALF{in_denom[HALF-1]}}, in_denom[HALF-1:0]}
                           : {{HALF{1'b0}}, in_denom[HALF-1:0]};
      min_ext  = {{(HALF + 1){1'b1}}, {(HALF - 1){1'b0}}};
      ones_ext = in_signed ? {WIDTH{1'b1}} : {{HALF{1'b0}}, {HALF{1'b1}}};
      load_cnt = CNT_W'(HALF / ITER_PER_CYCLE);
    end else begin
      num_ext  = in_num;
      den_ext  = in_denom;
      min_ext  = {1'b1, {(WIDTH - 1){1'b0}}};
      ones_ext = {WIDTH{1'b1}};
      load_cnt = CNT_W'(WIDTH / ITER_PER_CYCLE);
    end
    num_neg  = in_signed & num_ext[WIDTH-1];
    den_neg  = in_signed & den_ext[WIDTH-1];
    num_mag  = num_neg ? ('0 - num_ext) : num_ext;
    den_mag  = den_neg ? ('0 - den_ext) : den_ext;
    den_zero = (den_ext == '0);
    is_ovf   = in_signed && (num_ext == min_ext) && (den_ext == {WIDTH{1'b1}});
    // Left-align half-width dividends so the same shifter serves both modes
    load_q   = in_half ? (num_mag << HALF) : num_mag;
  end

  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH:0]   r_sh;

  // Restoring shift/compare-subtract steps performed in one clock
  always_comb begin
    q_nxt = q_r;
    r_nxt = r_r;
    r_sh  = '0;
    for (int i = 0; i < int'(ITER_PER_CYCLE); i++) begin
      r_sh  = {r_nxt, q_nxt[WIDTH-1]};
      q_nxt = {q_nxt[WIDTH-2:0], 1'b0};
      if (r_sh >= {1'b0, d_r}) begin
        r_sh     = r_sh - {1'b0, d_r};
        q_nxt[0] = 1'b1;
      end
      r_nxt = r_sh[WIDTH-1:0];
    end
  end

  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  // Sign fixup; upper half of q_r/r_r is zero in half mode, so negation sign-extends
  always_comb begin
    quot_fix = neg_q ? ('0 - q_r) : q_r;
    rem_fix  = neg_r ? ('0 - r_r) : r_r;
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      in_ready     <= 1'b1;
      cnt          <= '0;
      q_r          <= '0;
      r_r          <= '0;
      d_r          <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      out_valid    <= 1'b0;
      out_quot     <= '0;
      out_rem      <= '0;
      out_div_zero <= 1'b0;
      out_ovf      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && !flush) begin
            in_ready     <= 1'b0;
            out_div_zero <= 1'b0;
            out_ovf      <= 1'b0;
            if (den_zero) begin
              state        <= S_DONE;
              out_valid    <= 1'b1;
              out_quot     <= ones_ext;
              out_rem      <= num_ext;
              out_div_zero <= 1'b1;
            end else if (is_ovf) begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              out_quot  <= min_ext;
              out_rem   <= '0;
              out_ovf   <= 1'b1;
            end else begin
              state <= S_CALC;
              q_r   <= load_q;
              r_r   <= '0;
              d_r   <= den_mag;
              cnt   <= load_cnt;
              neg_q <= num_neg ^ den_neg;
              neg_r <= num_neg;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
          end else begin
            q_r <= q_nxt;
            r_r <= r_nxt;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state <= S_FIXUP;
            end
          end
        end
        S_FIXUP: begin
          if (flush) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
          end else begin
            out_quot  <= quot_fix;
            out_rem   <= rem_fix;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (flush || out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
